// File: rtl/control_pins.sv
// Shared motherboard/device control-pin encodings: command bits driven on ctrl
// and status codes reported on stat. Plain constants, no logic.
// Latency: n/a. Backpressure: n/a.
package control_pins;

    // Command bits on ctrl. Both set at once means "read".
    localparam int CTRL_READ  = 1;
    localparam int CTRL_WRITE = 2;

    // Status codes on stat.
    localparam int STAT_IDLE  = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_DONE  = 2;
    localparam int STAT_ERR   = 3;

endpackage

// File: rtl/dev_ram_pkg.sv
// Shared FSM state encodings for device-side (DEV_*) and motherboard-side
// (MOBO_*) handshake controllers, plus small elaboration helpers.
// Latency: n/a. Backpressure: n/a.
package dev_ram_pkg;

    typedef enum logic [1:0] {
        DEV_IDLE = 2'd0,
        DEV_BUSY = 2'd1,
        DEV_DONE = 2'd2
    } dev_state_t;

    typedef enum logic [1:0] {
        MOBO_IDLE  = 2'd0,
        MOBO_CMD   = 2'd1,
        MOBO_WAIT  = 2'd2,
        MOBO_CLEAR = 2'd3
    } mobo_state_t;

    // Address/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dev_ram_array.sv
// Single-port word memory: synchronous write, registered read.
// Latency: read data appears on rdata one edge after re; holds until next re.
// Backpressure: none; every we/re is serviced on the edge it is presented.
//
// Ports: clk, rst (async active-high, clears only the read register),
//        we/re strobes, addr word index, wdata write word, rdata read word.
// Storage itself is never reset.
module dev_ram_array #(
    parameter int word_width = 32,
    parameter int depth      = 1024,
    parameter int aw         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [aw-1:0]         addr,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rdata
);

    logic [word_width-1:0] mem_q [depth];
    logic [word_width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dev_ram.sv
// Motherboard-attached RAM device: command/status handshake around a word memory.
// Latency: command accepted at edge N -> stat = DONE after edge N+1+wait_cycles.
// Backpressure: stat holds DONE/ERR while ctrl != 0; new commands only taken in IDLE.
//
// Ports: clk, rst (async active-high), ctrl command word, stat status word,
//        addr word address, data_in write data, data_out read data (holds
//        until the next completed read).
// Optional build macro DEV_RAM_RANGE_CHECK_EN: addresses >= depth report STAT_ERR
// and skip the access; otherwise only the low address bits are used (wrap).
module dev_ram
    import control_pins::*;
    import dev_ram_pkg::*;
#(
    parameter int word_width  = 32,
    parameter int depth       = 1024,
    parameter int wait_cycles = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ctrl,
    output logic [word_width-1:0] stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out
);

    localparam int AW = clog2_min1(depth);
    localparam int CW = clog2_min1(wait_cycles + 1);

    localparam logic [word_width-1:0] CTRL_RD_W = word_width'(CTRL_READ);
    localparam logic [word_width-1:0] CTRL_WR_W = word_width'(CTRL_WRITE);

    dev_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [word_width-1:0] addr_q, addr_d;
    logic [word_width-1:0] data_q, data_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic [word_width-1:0] stat_q, stat_d;

    logic cmd_rd, cmd_wr, addr_ok, access, mem_we, mem_re;

    assign cmd_rd = |(ctrl & CTRL_RD_W);
    assign cmd_wr = |(ctrl & CTRL_WR_W);

`ifdef DEV_RAM_RANGE_CHECK_EN
    localparam logic [word_width:0] DEPTH_W = (word_width + 1)'(depth);
    assign addr_ok = ({1'b0, addr_q} < DEPTH_W);
`else
    // Upper address bits are deliberately dropped: the memory aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[word_width-1:AW];
    assign addr_ok        = 1'b1;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DEV_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            stat_q  <= word_width'(STAT_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            stat_q  <= stat_d;
        end
    end

    // Next-state and latch capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            DEV_IDLE: begin
                if (cmd_rd || cmd_wr) begin
                    state_d = DEV_BUSY;
                    cnt_d   = CW'(wait_cycles);
                    addr_d  = addr;
                    data_d  = data_in;
                    rd_d    = cmd_rd;   // read wins when both bits are set
                    err_d   = 1'b0;
                end
            end
            DEV_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DEV_DONE;
                    err_d   = !addr_ok;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DEV_DONE: begin
                if (ctrl == '0) begin
                    state_d = DEV_IDLE;
                end
            end
            default: begin
                state_d = DEV_IDLE;
            end
        endcase
    end

    // Outputs: memory strobes for the completing edge, and the status that
    // will be registered alongside the next state.
    always_comb begin
        access = (state_q == DEV_BUSY) && (cnt_q == '0) && addr_ok;
        mem_we = access && !rd_q;
        mem_re = access && rd_q;
        case (state_d)
            DEV_BUSY: stat_d = word_width'(STAT_BUSY);
            DEV_DONE: stat_d = err_d ? word_width'(STAT_ERR) : word_width'(STAT_DONE);
            default:  stat_d = word_width'(STAT_IDLE);
        endcase
    end

    assign stat = stat_q;

    dev_ram_array #(
        .word_width (word_width),
        .depth      (depth),
        .aw         (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q[AW-1:0]),
        .wdata (data_q),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_dev_ram.sv
module tb_dev_ram;
    import control_pins::*;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 2;

    localparam logic [31:0] S_IDLE = 32'(STAT_IDLE);
    localparam logic [31:0] S_BUSY = 32'(STAT_BUSY);
    localparam logic [31:0] S_DONE = 32'(STAT_DONE);
    localparam logic [31:0] S_ERR  = 32'(STAT_ERR);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] ctrl, addr, data_in, stat, data_out;
    logic [31:0] ctrl_s, addr_s, din_s;
    logic [31:0] stat_s0, stat_s1, stat_s5, dout_s0, dout_s1, dout_s5;

    dev_ram #(.word_width(32), .depth(DEPTH), .wait_cycles(WAIT)) u_dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat),
        .addr(addr), .data_in(data_in), .data_out(data_out));

    dev_ram #(.word_width(32), .depth(16), .wait_cycles(0)) u_w0 (
        .clk(clk), .rst(rst), .ctrl(ctrl_s), .stat(stat_s0),
        .addr(addr_s), .data_in(din_s), .data_out(dout_s0));
    dev_ram #(.word_width(32), .depth(16), .wait_cycles(1)) u_w1 (
        .clk(clk), .rst(rst), .ctrl(ctrl_s), .stat(stat_s1),
        .addr(addr_s), .data_in(din_s), .data_out(dout_s1));
    dev_ram #(.word_width(32), .depth(16), .wait_cycles(5)) u_w5 (
        .clk(clk), .rst(rst), .ctrl(ctrl_s), .stat(stat_s5),
        .addr(addr_s), .data_in(din_s), .data_out(dout_s5));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: word store keyed by effective index, plus last read word.
    logic [31:0] mem_m [int];
    int          keys[$];
    logic [31:0] dout_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Effective memory index for an address, or -1 if the access is rejected.
    function automatic int eff(input logic [31:0] a);
`ifdef DEV_RAM_RANGE_CHECK_EN
        if (a >= 32'(DEPTH)) return -1;
        return int'(a);
`else
        return int'(a % 32'(DEPTH));
`endif
    endfunction

    // Apply one command to the model; returns the status expected in DONE.
    function automatic logic [31:0] model_apply(input logic [31:0] c, input logic [31:0] a,
                                                input logic [31:0] d);
        int e;
        e = eff(a);
        if (e < 0) return S_ERR;
        if (c[0]) begin
            dout_m = mem_m[e];
        end else begin
            if (!mem_m.exists(e)) keys.push_back(e);
            mem_m[e] = d;
        end
        return S_DONE;
    endfunction

    // Issue a command, scramble inputs while BUSY, stop on the first non-BUSY status.
    task automatic run_op(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                          input bit drop_mid, output int busy_n, output logic [31:0] done_st);
        ctrl = c; addr = a; data_in = d;
        step();
        busy_n = 0;
        while (stat === S_BUSY && busy_n < 64) begin
            busy_n++;
            addr    = $urandom;
            data_in = $urandom;
            ctrl    = drop_mid ? 32'h0 : 32'($urandom_range(1, 3));
            step();
        end
        done_st = stat;
    endtask

    task automatic do_op(input string tag, input logic [31:0] c, input logic [31:0] a,
                         input logic [31:0] d);
        int          busy_n;
        logic [31:0] st, exp_st;
        run_op(c, a, d, 1'b0, busy_n, st);
        exp_st = model_apply(c, a, d);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WAIT + 1));
        check({tag, "_stat_done"}, st, exp_st);
        check({tag, "_data_out"}, data_out, dout_m);
        ctrl = 32'h0;
        step();
        check({tag, "_stat_idle"}, stat, S_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          busy_n, n0, n1, n5;
        logic [31:0] st, exp_st, a, c;

        rst = 1'b1; ctrl = '0; addr = '0; data_in = '0;
        ctrl_s = '0; addr_s = '0; din_s = '0;
        dout_m = '0;
        #12;
        check("reset_stat", stat, S_IDLE);
        check("reset_data_out", data_out, 32'h0);
        rst = 1'b0;
        step();

        // Neither command bit set: ignored.
        ctrl = 32'h4;
        step(); step();
        check("ignore_ctrl4", stat, S_IDLE);
        ctrl = 32'h0;
        step();

        // Write then read back.
        do_op("wr5", 32'd2, 32'd5, 32'hDEADBEEF);
        do_op("rd5", 32'd1, 32'd5, 32'h0);
        check("rd5_literal", data_out, 32'hDEADBEEF);

        // Both bits set performs a read and leaves memory alone.
        do_op("both5", 32'd3, 32'd5, 32'h12345678);
        check("both5_literal", data_out, 32'hDEADBEEF);
        do_op("rd5_again", 32'd1, 32'd5, 32'h0);
        check("rd5_again_literal", data_out, 32'hDEADBEEF);

        // Hold ctrl in DONE for 10 cycles, then release.
        run_op(32'd2, 32'd9, 32'hA5A5A5A5, 1'b0, busy_n, st);
        exp_st = model_apply(32'd2, 32'd9, 32'hA5A5A5A5);
        check("hold_stat", st, exp_st);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_stays_done", stat, S_DONE);
        end
        ctrl = 32'h0;
        step();
        check("hold_release_idle", stat, S_IDLE);

        // Drop ctrl mid-BUSY: one-cycle DONE, write still committed.
        run_op(32'd2, 32'd11, 32'h11111111, 1'b1, busy_n, st);
        exp_st = model_apply(32'd2, 32'd11, 32'h11111111);
        check("drop_busy_cycles", 32'(busy_n), 32'(WAIT + 1));
        check("drop_stat_done", st, exp_st);
        step();
        check("drop_one_cycle_done", stat, S_IDLE);
        do_op("drop_rd11", 32'd1, 32'd11, 32'h0);

        // Reset during an in-flight write to addr 7.
        do_op("pre_wr7", 32'd2, 32'd7, 32'h77770000);
        ctrl = 32'd2; addr = 32'd7; data_in = 32'hBAD0BAD0;
        step();
        check("rst_mid_busy", stat, S_BUSY);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_stat", stat, S_IDLE);
        check("rst_mid_data_out", data_out, 32'h0);
        dout_m = '0;
        ctrl = 32'h0;
        step();
        rst = 1'b0;
        step();
        do_op("post_rst_rd7", 32'd1, 32'd7, 32'h0);
        check("post_rst_rd7_literal", data_out, 32'h77770000);

        // Address edge at depth.
        do_op("wr0", 32'd2, 32'd0, 32'h0A0A0A0A);
        do_op("wr1024", 32'd2, 32'd1024, 32'hC0FFEE00);
        do_op("rd0", 32'd1, 32'd0, 32'h0);
        do_op("rd1024", 32'd1, 32'd1024, 32'h0);

        // Randomized traffic; reads only target previously written words.
        for (int i = 0; i < 40; i++) begin
            c = 32'($urandom_range(1, 3));
            if (c[0]) begin
                a = 32'(keys[$urandom_range(0, keys.size() - 1)]);
                if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * $urandom_range(1, 3));
            end else begin
                a = 32'($urandom_range(0, DEPTH + 15));
            end
            do_op("rand", c, a, $urandom);
        end

        // Latency sweep on wait_cycles = 0, 1, 5.
        n0 = 0; n1 = 0; n5 = 0;
        ctrl_s = 32'd2; addr_s = 32'd1; din_s = 32'hFACE0001;
        step();
        for (int i = 0; i < 20; i++) begin
            if (stat_s0 === S_BUSY) n0++;
            if (stat_s1 === S_BUSY) n1++;
            if (stat_s5 === S_BUSY) n5++;
            step();
        end
        check("sweep_w0_busy", 32'(n0), 32'd1);
        check("sweep_w1_busy", 32'(n1), 32'd2);
        check("sweep_w5_busy", 32'(n5), 32'd6);
        check("sweep_w0_done", stat_s0, S_DONE);
        check("sweep_w1_done", stat_s1, S_DONE);
        check("sweep_w5_done", stat_s5, S_DONE);
        ctrl_s = 32'h0;
        step();
        check("sweep_w0_idle", stat_s0, S_IDLE);
        check("sweep_w5_idle", stat_s5, S_IDLE);
        ctrl_s = 32'd1;
        step();
        for (int i = 0; i < 10; i++) step();
        check("sweep_w0_rd", dout_s0, 32'hFACE0001);
        check("sweep_w1_rd", dout_s1, 32'hFACE0001);
        check("sweep_w5_rd", dout_s5, 32'hFACE0001);
        ctrl_s = 32'h0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
